// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: bus widths, opcode constants,
// FSM state encoding and the opcode legality check.
package alu_seq_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned CNT_W   = 4;

  localparam logic [OP_W-1:0] ADD    = 6'd0;
  localparam logic [OP_W-1:0] SUB    = 6'd1;
  localparam logic [OP_W-1:0] MUL    = 6'd2;
  localparam logic [OP_W-1:0] DIV    = 6'd3;
  localparam logic [OP_W-1:0] SLL    = 6'd4;
  localparam logic [OP_W-1:0] SRL    = 6'd5;
  localparam logic [OP_W-1:0] AND    = 6'd6;
  localparam logic [OP_W-1:0] OR     = 6'd7;
  localparam logic [OP_W-1:0] XOR    = 6'd8;
  localparam logic [OP_W-1:0] SLT    = 6'd9;
  localparam logic [OP_W-1:0] ADDF   = 6'd10;
  localparam logic [OP_W-1:0] SUBF   = 6'd11;
  localparam logic [OP_W-1:0] MULF   = 6'd12;
  localparam logic [OP_W-1:0] DIVF   = 6'd13;
  localparam logic [OP_W-1:0] OP_MAX = 6'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Opcodes above OP_MAX have no ALU function behind them.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request / ALU / response bundle of the ALU sequencer.
//   slave  : sequencer side (accepts requests, drives the ALU, returns results)
//   master : requester + ALU side
// resp_err exists only when ALU_SEQ_ERR_EN is defined.
interface alu_seq_ctrl_if import alu_seq_pkg::*; ();

  logic               req_valid;
  logic               req_ready;
  logic [OP_W-1:0]    req_op;
  logic [DATA_W-1:0]  req_a;
  logic [DATA_W-1:0]  req_b;
  logic [SHAMT_W-1:0] req_shamt;
  logic [OP_W-1:0]    alu_con;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [SHAMT_W-1:0] alu_shamt;
  logic [DATA_W-1:0]  alu_result;
  logic               resp_valid;
  logic               resp_ready;
  logic [DATA_W-1:0]  resp_data;
  logic               busy;
`ifdef ALU_SEQ_ERR_EN
  logic               resp_err;
`endif

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_shamt, alu_result, resp_ready,
    output req_ready, alu_con, alu_a, alu_b, alu_shamt, resp_valid, resp_data, busy
`ifdef ALU_SEQ_ERR_EN
    , output resp_err
`endif
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_shamt, alu_result, resp_ready,
    input  req_ready, alu_con, alu_a, alu_b, alu_shamt, resp_valid, resp_data, busy
`ifdef ALU_SEQ_ERR_EN
    , input resp_err
`endif
  );

endinterface

// File: rtl/alu_lat_counter.sv
// Opcode-to-latency lookup and 4-bit down-counter for the ALU sequencer.
//   clk, rst : clock, synchronous active-high reset
//   load     : load the latency of op
//   dec      : count down one step (held while the operation is in flight)
//   op       : opcode whose latency class is loaded
//   last_c   : counter equals 1, i.e. the result is due at this edge
module alu_lat_counter
  import alu_seq_pkg::*;
#(
  parameter int unsigned INT_LAT  = 1,
  parameter int unsigned FADD_LAT = 3,
  parameter int unsigned FMUL_LAT = 3,
  parameter int unsigned FDIV_LAT = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            dec,
  input  logic [OP_W-1:0] op,
  output logic            last_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] lat_c;

  // Latency class lookup; integer ops and unknown opcodes share INT_LAT.
  always_comb begin
    lat_c = CNT_W'(INT_LAT);
    case (op)
      ADDF, SUBF: lat_c = CNT_W'(FADD_LAT);
      MULF:       lat_c = CNT_W'(FMUL_LAT);
      DIVF:       lat_c = CNT_W'(FDIV_LAT);
      default:    lat_c = CNT_W'(INT_LAT);
    endcase
  end

  // Down-counter; load wins so a back-to-back accept restarts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= lat_c;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign last_c = (count_q == CNT_W'(1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencer: accepts one request at a time, presents the operands to an
// external ALU, waits the opcode's latency, captures the result and holds it
// until the consumer takes it. A new request may be accepted in the same
// cycle a response is consumed.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_seq_ctrl_if.slave (request, ALU drive/result, response, busy)
// Optional: ALU_SEQ_ERR_EN adds resp_err and traps opcodes above OP_MAX.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned INT_LAT  = 1,
  parameter int unsigned FADD_LAT = 3,
  parameter int unsigned FMUL_LAT = 3,
  parameter int unsigned FDIV_LAT = 6
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    alu_con_q, alu_con_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [SHAMT_W-1:0] alu_shamt_q, alu_shamt_d;
  logic               resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;
  logic               accept_c;
  logic               trap_c;
  logic               load_c;
  logic               last_c;

  // Ready in IDLE, or in RESP when the held response is being consumed.
  assign bus.req_ready = !rst && ((state_q == IDLE) ||
                                  ((state_q == RESP) && bus.resp_ready));
  assign accept_c = bus.req_valid && bus.req_ready;

`ifdef ALU_SEQ_ERR_EN
  assign trap_c = !op_is_legal(bus.req_op);
`else
  assign trap_c = 1'b0;
`endif

  alu_lat_counter #(
    .INT_LAT  (INT_LAT),
    .FADD_LAT (FADD_LAT),
    .FMUL_LAT (FMUL_LAT),
    .FDIV_LAT (FDIV_LAT)
  ) u_lat (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .dec    (state_q == BUSY),
    .op     (bus.req_op),
    .last_c (last_c)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    alu_con_d    = alu_con_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_shamt_d  = alu_shamt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    load_c       = 1'b0;

    case (state_q)
      BUSY: begin
        if (last_c) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = bus.alu_result;
          resp_err_d   = 1'b0;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
        end
      end
      default: ;
    endcase

    // Accept overrides the response drain above, giving no idle bubble.
    if (accept_c) begin
      alu_a_d     = bus.req_a;
      alu_b_d     = bus.req_b;
      alu_shamt_d = bus.req_shamt;
      if (trap_c) begin
        // Illegal opcode: park the ALU on ADD and answer immediately.
        alu_con_d    = ADD;
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = '0;
        resp_err_d   = 1'b1;
      end else begin
        alu_con_d    = bus.req_op;
        state_d      = BUSY;
        resp_valid_d = 1'b0;
        load_c       = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_con_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_shamt_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_con_q    <= alu_con_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_shamt_q  <= alu_shamt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.alu_con    = alu_con_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_shamt  = alu_shamt_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = (state_q != IDLE);

`ifdef ALU_SEQ_ERR_EN
  assign bus.resp_err = resp_err_q;
`else
  logic unused_err;
  assign unused_err = resp_err_q;
`endif

endmodule
